// File: rtl/jtopl_pkg.sv
// Shared constants and small helpers for the OPL CPU-side register decoder.
// Register addresses, opcode nibbles and the strobe bundle used by jtopl_mmr_banked.
package jtopl_pkg;

  localparam logic [7:0] REG_CLKA  = 8'h02;
  localparam logic [7:0] REG_CLKB  = 8'h03;
  localparam logic [7:0] REG_TIMER = 8'h04;
  localparam logic [7:0] REG_RHY   = 8'hBD;
  localparam logic [7:0] REG_CONN  = 8'h04;
  localparam logic [7:0] REG_NEW   = 8'h05;

  // Operator register families, selected by address bits [7:5]
  localparam logic [2:0] OP_MULT   = 3'd1;
  localparam logic [2:0] OP_KSL_TL = 3'd2;
  localparam logic [2:0] OP_AR_DR  = 3'd3;
  localparam logic [2:0] OP_SL_RR  = 3'd4;

  // Channel register families, selected by address bits [7:4]
  localparam logic [3:0] CH_FNUMLO = 4'hA;
  localparam logic [3:0] CH_FNUMHI = 4'hB;
  localparam logic [3:0] CH_FBCON  = 4'hC;

  typedef struct packed {
    logic mult;
    logic ksl_tl;
    logic ar_dr;
    logic sl_rr;
    logic fnumlo;
    logic fnumhi;
    logic fbcon;
  } up_t;

  function automatic logic [1:0] ch_group(input logic [3:0] lo);
    if (lo < 4'd3)      return 2'd0;
    else if (lo < 4'd6) return 2'd1;
    else                return 2'd2;
  endfunction

  // Channels 6..8 fold onto sub-slots 0..2 of group 2
  function automatic logic [2:0] ch_sub(input logic [3:0] lo);
    if (lo < 4'd6) return lo[2:0];
    else           return {1'b0, ~&lo[2:1], lo[0]};
  endfunction

endpackage

// File: rtl/jtopl_wrbusy.sv
// Write-busy window: loads BUSY_CYC on an accepted data write, counts down on cenop,
// and pulses expire on the clock where the count reaches zero.
module jtopl_wrbusy #(
  parameter int BUSY_CYC = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic cenop,
  input  logic load,
  output logic busy,
  output logic expire
);

  localparam int CW = (BUSY_CYC < 2) ? 1 : $clog2(BUSY_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(BUSY_CYC);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          busy_reg;

  always_comb begin
    cnt_next = cnt_reg;
    expire   = 1'b0;
    if (load) begin
      cnt_next = LOAD_VAL;
    end else if (cenop && cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
      expire   = (cnt_reg == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      busy_reg <= (cnt_next != '0);
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/jtopl_mmr_banked.sv
// CPU-side register decoder for OPL2/OPL3 register maps with busy window and lost-write flag.
// Optional 4-operator support (conn_sel, NEW gating of bank 1) is enabled by JTOPL_4OP_EN.
module jtopl_mmr_banked
  import jtopl_pkg::*;
#(
  parameter int BANKS    = 1,
  parameter int BUSY_CYC = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cenop,
  input  logic [7:0] din,
  input  logic [1:0] addr,
  input  logic       write,
  input  logic       read,
  output logic [7:0] dout,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic       busy,
  output logic [7:0] din_copy,
  output logic       sel_bank,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       clr_flag,
  output logic       am_dep,
  output logic       vib_dep,
  output logic       rhy_en,
  output logic [4:0] rhy_kon,
  output logic [5:0] conn_sel
);

  localparam logic TWO_BANKS = (BANKS == 2);

  logic [7:0] selreg_reg, din_copy_reg, value_A_reg, value_B_reg;
  logic       selbank_reg, wr_lost_reg, sel_bank_reg;
  logic [1:0] sel_group_reg, grp_dec;
  logic [2:0] sel_sub_reg, sub_dec;
  up_t        up_reg, up_dec;
  logic       load_A_reg, load_B_reg, flagen_A_reg, flagen_B_reg, clr_flag_reg;
  logic       am_dep_reg, vib_dep_reg, rhy_en_reg;
  logic [4:0] rhy_kon_reg;

  logic addr_wr, data_wr, accept, lost, expire, decode_en, op_hit, ch_hit, irq;

  assign addr_wr = write & ~addr[0];
  assign data_wr = write & addr[0];
  assign accept  = data_wr & ~busy;
  assign lost    = data_wr & busy;

  jtopl_wrbusy #(.BUSY_CYC(BUSY_CYC)) u_wrbusy (
    .clk    (clk),
    .rst    (rst),
    .cenop  (cenop),
    .load   (accept),
    .busy   (busy),
    .expire (expire)
  );

`ifdef JTOPL_4OP_EN
  logic [5:0] conn_sel_reg;
  logic       new_reg;

  // Bank 1 operator/channel registers only exist once NEW is set
  assign decode_en = ~selbank_reg | new_reg;
  assign conn_sel  = conn_sel_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      conn_sel_reg <= '0;
      new_reg      <= 1'b0;
    end else if (accept && selbank_reg) begin
      if (selreg_reg == REG_CONN) conn_sel_reg <= din[5:0];
      if (selreg_reg == REG_NEW)  new_reg      <= din[0];
    end
  end
`else
  assign decode_en = 1'b1;
  assign conn_sel  = '0;
`endif

  assign op_hit = decode_en && selreg_reg[7:5] >= OP_MULT && selreg_reg[7:5] <= OP_SL_RR
                  && selreg_reg[2:0] <= 3'd5 && selreg_reg[4:3] != 2'd3;
  assign ch_hit = decode_en && selreg_reg[7:4] >= CH_FNUMLO && selreg_reg[7:4] <= CH_FBCON
                  && selreg_reg[3:0] <= 4'd8;

  always_comb begin
    up_dec  = '0;
    grp_dec = sel_group_reg;
    sub_dec = sel_sub_reg;
    if (op_hit) begin
      grp_dec = selreg_reg[4:3];
      sub_dec = selreg_reg[2:0];
      case (selreg_reg[7:5])
        OP_MULT:   up_dec.mult   = 1'b1;
        OP_KSL_TL: up_dec.ksl_tl = 1'b1;
        OP_AR_DR:  up_dec.ar_dr  = 1'b1;
        OP_SL_RR:  up_dec.sl_rr  = 1'b1;
        default:   ;
      endcase
    end else if (ch_hit) begin
      grp_dec = ch_group(selreg_reg[3:0]);
      sub_dec = ch_sub(selreg_reg[3:0]);
      case (selreg_reg[7:4])
        CH_FNUMLO: up_dec.fnumlo = 1'b1;
        CH_FNUMHI: up_dec.fnumhi = 1'b1;
        CH_FBCON:  up_dec.fbcon  = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      selreg_reg    <= '0;
      selbank_reg   <= 1'b0;
      wr_lost_reg   <= 1'b0;
      din_copy_reg  <= '0;
      sel_bank_reg  <= 1'b0;
      sel_group_reg <= '0;
      sel_sub_reg   <= '0;
      up_reg        <= '0;
      value_A_reg   <= '0;
      value_B_reg   <= '0;
      load_A_reg    <= 1'b0;
      load_B_reg    <= 1'b0;
      flagen_A_reg  <= 1'b1;
      flagen_B_reg  <= 1'b1;
      clr_flag_reg  <= 1'b0;
      am_dep_reg    <= 1'b0;
      vib_dep_reg   <= 1'b0;
      rhy_en_reg    <= 1'b0;
      rhy_kon_reg   <= '0;
    end else begin
      if (addr_wr) begin
        selreg_reg  <= din;
        selbank_reg <= addr[1] & TWO_BANKS;
      end
      // A write lost on the same clock as a status read keeps the flag set
      if (lost)      wr_lost_reg <= 1'b1;
      else if (read) wr_lost_reg <= 1'b0;
      if (cenop && !write) clr_flag_reg <= 1'b0;
      if (accept) begin
        din_copy_reg  <= din;
        sel_bank_reg  <= selbank_reg;
        up_reg        <= up_dec;
        sel_group_reg <= grp_dec;
        sel_sub_reg   <= sub_dec;
        if (!selbank_reg) begin
          case (selreg_reg)
            REG_CLKA: value_A_reg <= din;
            REG_CLKB: value_B_reg <= din;
            REG_TIMER: begin
              clr_flag_reg <= din[7];
              flagen_A_reg <= ~din[6];
              flagen_B_reg <= ~din[5];
              load_B_reg   <= din[1];
              load_A_reg   <= din[0];
            end
            REG_RHY: begin
              am_dep_reg  <= din[7];
              vib_dep_reg <= din[6];
              rhy_en_reg  <= din[5];
              rhy_kon_reg <= din[4:0];
            end
            default: ;
          endcase
        end
      end else if (expire) begin
        up_reg <= '0;
      end
    end
  end

  assign irq  = (flag_A & flagen_A_reg) | (flag_B & flagen_B_reg);
  assign dout = {irq, flag_A, flag_B, 2'b00, wr_lost_reg, busy, 1'b0};

  assign din_copy  = din_copy_reg;
  assign sel_bank  = sel_bank_reg;
  assign sel_group = sel_group_reg;
  assign sel_sub   = sel_sub_reg;
  assign up_mult   = up_reg.mult;
  assign up_ksl_tl = up_reg.ksl_tl;
  assign up_ar_dr  = up_reg.ar_dr;
  assign up_sl_rr  = up_reg.sl_rr;
  assign up_fnumlo = up_reg.fnumlo;
  assign up_fnumhi = up_reg.fnumhi;
  assign up_fbcon  = up_reg.fbcon;
  assign value_A   = value_A_reg;
  assign value_B   = value_B_reg;
  assign load_A    = load_A_reg;
  assign load_B    = load_B_reg;
  assign flagen_A  = flagen_A_reg;
  assign flagen_B  = flagen_B_reg;
  assign clr_flag  = clr_flag_reg;
  assign am_dep    = am_dep_reg;
  assign vib_dep   = vib_dep_reg;
  assign rhy_en    = rhy_en_reg;
  assign rhy_kon   = rhy_kon_reg;

endmodule

// File: tb/tb_jtopl_mmr_banked.sv
// Bench for jtopl_mmr_banked (two-bank map): directed register checks, then random CPU traffic
// compared every cycle against a behavioural register-map model.
module tb_jtopl_mmr_banked;

  localparam int BANKS    = 2;
  localparam int BUSY_CYC = 18;

  logic       clk = 1'b0;
  logic       rst, cenop, write, read, flag_A, flag_B;
  logic [7:0] din;
  logic [1:0] addr;
  logic [7:0] dout, din_copy, value_A, value_B;
  logic       busy, sel_bank;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnumlo, up_fnumhi, up_fbcon;
  logic       load_A, load_B, flagen_A, flagen_B, clr_flag, am_dep, vib_dep, rhy_en;
  logic [4:0] rhy_kon;
  logic [5:0] conn_sel;

  int n_cmp = 0;
  int n_err = 0;

  jtopl_mmr_banked #(.BANKS(BANKS), .BUSY_CYC(BUSY_CYC)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .din(din), .addr(addr), .write(write), .read(read),
    .dout(dout), .flag_A(flag_A), .flag_B(flag_B), .busy(busy), .din_copy(din_copy),
    .sel_bank(sel_bank), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flag(clr_flag),
    .am_dep(am_dep), .vib_dep(vib_dep), .rhy_en(rhy_en), .rhy_kon(rhy_kon), .conn_sel(conn_sel)
  );

  always #5 clk = ~clk;

  // Behavioural model: register map state as plain integers
  int m_selreg, m_selbank, m_cnt, m_wr_lost, m_din_copy, m_sel_bank, m_group, m_sub;
  int m_up [0:6];  // mult, ksl_tl, ar_dr, sl_rr, fnumlo, fnumhi, fbcon
  int m_va, m_vb, m_lda, m_ldb, m_fea, m_feb, m_clr, m_am, m_vib, m_rhy, m_kon, m_conn, m_new;

  task automatic model_reset();
    m_selreg = 0; m_selbank = 0; m_cnt = 0; m_wr_lost = 0; m_din_copy = 0;
    m_sel_bank = 0; m_group = 0; m_sub = 0;
    for (int i = 0; i < 7; i++) m_up[i] = 0;
    m_va = 0; m_vb = 0; m_lda = 0; m_ldb = 0; m_fea = 1; m_feb = 1; m_clr = 0;
    m_am = 0; m_vib = 0; m_rhy = 0; m_kon = 0; m_conn = 0; m_new = 0;
  endtask

  task automatic model_step();
    int r, lo, hi, d;
    bit busy_now, accept, ok;
    if (rst) begin
      model_reset();
      return;
    end
    r = m_selreg;
    d = int'(din);
    busy_now = (m_cnt > 0);
    accept = write && addr[0] && !busy_now;
    if (write && !addr[0]) begin
      m_selreg  = d;
      m_selbank = (BANKS == 2) ? int'(addr[1]) : 0;
    end
    if (write && addr[0] && busy_now) m_wr_lost = 1;
    else if (read) m_wr_lost = 0;
    if (cenop && !write) m_clr = 0;
    if (accept) begin
      m_cnt = BUSY_CYC;
    end else if (cenop && m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0)
        for (int i = 0; i < 7; i++) m_up[i] = 0;
    end
    if (accept) begin
      m_din_copy = d;
      m_sel_bank = m_selbank;
      for (int i = 0; i < 7; i++) m_up[i] = 0;
      if (m_selbank == 0) begin
        if (r == 2) m_va = d;
        if (r == 3) m_vb = d;
        if (r == 4) begin
          m_clr = d / 128;
          m_fea = 1 - (d / 64) % 2;
          m_feb = 1 - (d / 32) % 2;
          m_ldb = (d / 2) % 2;
          m_lda = d % 2;
        end
        if (r == 'hBD) begin
          m_am = d / 128; m_vib = (d / 64) % 2; m_rhy = (d / 32) % 2; m_kon = d % 32;
        end
      end
      ok = 1;
`ifdef JTOPL_4OP_EN
      ok = (m_selbank == 0) || (m_new != 0);
      if (m_selbank != 0 && r == 4) m_conn = d % 64;
      if (m_selbank != 0 && r == 5) m_new = d % 2;
`endif
      lo = r % 16;
      hi = r / 16;
      if (ok && r >= 'h20 && r <= 'h9F && r % 8 <= 5 && (r / 8) % 4 != 3) begin
        m_group = (r / 8) % 4;
        m_sub   = r % 8;
        m_up[r / 32 - 1] = 1;
      end else if (ok && hi >= 10 && hi <= 12 && lo <= 8) begin
        m_group = lo / 3;
        m_sub   = (lo < 6) ? lo : lo % 3;
        m_up[4 + hi - 10] = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int irq, e_dout;
    irq = (int'(flag_A) & m_fea) | (int'(flag_B) & m_feb);
    e_dout = irq * 128 + int'(flag_A) * 64 + int'(flag_B) * 32 + m_wr_lost * 4 + ((m_cnt > 0) ? 2 : 0);
    chk("dout", int'(dout), e_dout);
    chk("busy", int'(busy), (m_cnt > 0) ? 1 : 0);
    chk("din_copy", int'(din_copy), m_din_copy);
    chk("sel_bank", int'(sel_bank), m_sel_bank);
    chk("sel_group", int'(sel_group), m_group);
    chk("sel_sub", int'(sel_sub), m_sub);
    chk("up_mult", int'(up_mult), m_up[0]);
    chk("up_ksl_tl", int'(up_ksl_tl), m_up[1]);
    chk("up_ar_dr", int'(up_ar_dr), m_up[2]);
    chk("up_sl_rr", int'(up_sl_rr), m_up[3]);
    chk("up_fnumlo", int'(up_fnumlo), m_up[4]);
    chk("up_fnumhi", int'(up_fnumhi), m_up[5]);
    chk("up_fbcon", int'(up_fbcon), m_up[6]);
    chk("value_A", int'(value_A), m_va);
    chk("value_B", int'(value_B), m_vb);
    chk("load_A", int'(load_A), m_lda);
    chk("load_B", int'(load_B), m_ldb);
    chk("flagen_A", int'(flagen_A), m_fea);
    chk("flagen_B", int'(flagen_B), m_feb);
    chk("clr_flag", int'(clr_flag), m_clr);
    chk("am_dep", int'(am_dep), m_am);
    chk("vib_dep", int'(vib_dep), m_vib);
    chk("rhy_en", int'(rhy_en), m_rhy);
    chk("rhy_kon", int'(rhy_kon), m_kon);
    chk("conn_sel", int'(conn_sel), m_conn);
  endtask

  // One clock: drive inputs, let DUT and model take the edge, compare at the falling edge
  task automatic step(input bit w, input bit rd, input bit bank, input bit is_data,
                      input logic [7:0] d, input bit ce);
    write = w; read = rd; addr = {bank, is_data}; din = d; cenop = ce;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (w)
      $display("t=%0t %s bank=%0b din=%02h rd=%0b busy=%0b", $time, is_data ? "DATA" : "ADDR",
               bank, d, rd, busy);
    else if (rd)
      $display("t=%0t READ dout=%02h", $time, dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 1);
  endtask

  task automatic reg_write(input bit bank, input logic [7:0] a, input logic [7:0] d);
    step(1, 0, bank, 0, a, 0);
    step(1, 0, bank, 1, d, 0);
  endtask

  logic [7:0] picks [0:4];

  initial begin
    int nb, op;
    logic [7:0] a;
    picks[0] = 8'h02; picks[1] = 8'h03; picks[2] = 8'h04; picks[3] = 8'h05; picks[4] = 8'hBD;
    model_reset();
    rst = 1'b1; flag_A = 1'b0; flag_B = 1'b0;
    write = 1'b0; read = 1'b0; addr = 2'b00; din = 8'h00; cenop = 1'b0;
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    rst = 1'b0;
    step(0, 0, 0, 0, 8'h00, 0);
    chk("reset dout", int'(dout), 0);
    chk("reset flagen_A", int'(flagen_A), 1);
    chk("reset flagen_B", int'(flagen_B), 1);
    chk("reset busy", int'(busy), 0);

    reg_write(0, 8'h02, 8'h5A);
    chk("value_A 0x5A", int'(value_A), 'h5A);
    nb = int'(busy);
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 0, 8'h00, 1);
      nb += int'(busy);
    end
    chk("busy cenop ticks", nb, 18);

    reg_write(0, 8'h35, 8'h11);
    chk("0x35 up_mult", int'(up_mult), 1);
    chk("0x35 up_ksl_tl", int'(up_ksl_tl), 0);
    chk("0x35 sel_group", int'(sel_group), 2);
    chk("0x35 sel_sub", int'(sel_sub), 5);
    step(1, 0, 0, 1, 8'h77, 0);
    chk("lost din_copy", int'(din_copy), 'h11);
    chk("lost dout[2]", int'(dout[2]), 1);
    step(0, 1, 0, 0, 8'h00, 0);
    chk("read dout[2]", int'(dout[2]), 0);
    idle(20);
    chk("expired up_mult", int'(up_mult), 0);

    reg_write(1, 8'h05, 8'h01);
    idle(20);
    reg_write(1, 8'hA7, 8'h40);
    chk("A7 sel_bank", int'(sel_bank), 1);
    chk("A7 up_fnumlo", int'(up_fnumlo), 1);
    chk("A7 sel_group", int'(sel_group), 2);
    chk("A7 sel_sub", int'(sel_sub), 1);
    idle(20);
    reg_write(1, 8'h02, 8'h99);
    chk("bank1 value_A", int'(value_A), 'h5A);
    idle(20);
    reg_write(1, 8'h04, 8'h3F);
`ifdef JTOPL_4OP_EN
    chk("conn_sel", int'(conn_sel), 'h3F);
`else
    chk("conn_sel", int'(conn_sel), 0);
`endif
    idle(20);
    reg_write(0, 8'h04, 8'hE3);
    chk("timer clr_flag", int'(clr_flag), 1);
    chk("timer flagen_A", int'(flagen_A), 0);
    chk("timer load_A", int'(load_A), 1);
    step(0, 0, 0, 0, 8'h00, 1);
    chk("clr_flag self-clear", int'(clr_flag), 0);
    idle(20);

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 15) == 0) begin
        flag_A = 1'($urandom); flag_B = 1'($urandom);
      end
      case ($urandom_range(0, 3))
        0: a = 8'($urandom);
        1: a = {3'($urandom_range(1, 4)), 5'($urandom)};
        2: a = 8'(8'hA0 + 16 * $urandom_range(0, 2) + $urandom_range(0, 9));
        default: a = picks[$urandom_range(0, 4)];
      endcase
      op = $urandom_range(0, 99);
      if (op < 15)      step(1, ($urandom_range(0, 9) == 0), 1'($urandom), 0, a, 1'($urandom));
      else if (op < 35) step(1, ($urandom_range(0, 9) == 0), 1'($urandom), 1, 8'($urandom), 1'($urandom));
      else if (op < 45) step(0, 1, 0, 0, 8'h00, 1'($urandom));
      else              step(0, 0, 0, 0, 8'h00, 1'($urandom));
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
